// File: rtl/wb_buffered_stage.sv
// Write-back stage: registers accepted MEM/WB instructions, buffers register-file writes in a
// DEPTH-entry FIFO, emits a one-cycle PC redirect, tracks halt and counts retired instructions.
module wb_buffered_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  branch_pc,
  input  logic [DATA_W-1:0]  j_addr,
  input  logic [DATA_W-1:0]  ex_out,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [DATA_W-1:0]  pc2,
  input  logic               mem_to_reg,
  input  logic               j_jal,
  input  logic               jr_jalr,
  input  logic               jal_jalr,
  input  logic               br_taken,
  input  logic               reg_we,
  input  logic [RADDR_W-1:0] wr_addr_in,
  input  logic               halt_in,
  input  logic               rf_wr_ready,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  output logic               redirect_valid,
  output logic [DATA_W-1:0]  new_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [RADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               halt_seen_q, halted_q;
  logic               redirect_q;
  logic [DATA_W-1:0]  new_pc_q, new_pc_d;
  logic [CNT_W-1:0]   retired_q;

  logic               empty, accept, push, pop, redir_take;
  logic [DATA_W-1:0]  wb_value;

  assign empty      = (count_q == '0);
  assign in_ready   = (count_q < DEPTH_C) & ~halt_seen_q;
  assign accept     = in_valid & in_ready;
  assign push       = accept & reg_we;
  assign rf_wr_en   = ~empty;
  assign pop        = rf_wr_en & rf_wr_ready;
  assign redir_take = accept & (jr_jalr | j_jal | br_taken);

  assign wb_value   = jal_jalr ? pc2 : (mem_to_reg ? mem_data : ex_out);
  assign rf_wr_addr = addr_mem_q[rd_ptr_q];
  assign rf_wr_data = data_mem_q[rd_ptr_q];

  // halted is visible in the very cycle the drain completes, then held sticky
  assign halted         = halted_q | (halt_seen_q & empty);
  assign redirect_valid = redirect_q;
  assign new_pc         = new_pc_q;
  assign retired        = retired_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    new_pc_d = new_pc_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (redir_take) begin
      if (jr_jalr)    new_pc_d = ex_out;
      else if (j_jal) new_pc_d = j_addr;
      else            new_pc_d = branch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      redirect_q  <= 1'b0;
      new_pc_q    <= '0;
      retired_q   <= '0;
    end else begin
      if (push) begin
        addr_mem_q[wr_ptr_q] <= wr_addr_in;
        data_mem_q[wr_ptr_q] <= wb_value;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      halt_seen_q <= halt_seen_q | (accept & halt_in);
      halted_q    <= halted;
      redirect_q  <= redir_take;
      new_pc_q    <= new_pc_d;
      retired_q   <= retired_q + CNT_W'(accept);
    end
  end

endmodule

// File: tb/tb_wb_buffered_stage.sv
// Self-checking bench for wb_buffered_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_buffered_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, mem_to_reg, j_jal, jr_jalr, jal_jalr, br_taken, reg_we, halt_in, rf_wr_ready;
  logic [15:0] branch_pc, j_addr, ex_out, mem_data, pc2;
  logic [2:0]  wr_addr_in;
  logic        in_ready, rf_wr_en, redirect_valid, halted;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data, new_pc, retired;
  logic        in_ready4, rf_wr_en4, redirect_valid4, halted4;
  logic [2:0]  rf_wr_addr4;
  logic [15:0] rf_wr_data4, new_pc4;
  logic [3:0]  retired4;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [2:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  bit          m_hs, m_hsticky, m_redir;
  logic [15:0] m_newpc;
  int          m_retired;

  always #5 clk = ~clk;

  wb_buffered_stage #(.DATA_W(16), .RADDR_W(3), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .branch_pc(branch_pc), .j_addr(j_addr), .ex_out(ex_out), .mem_data(mem_data), .pc2(pc2),
    .mem_to_reg(mem_to_reg), .j_jal(j_jal), .jr_jalr(jr_jalr), .jal_jalr(jal_jalr),
    .br_taken(br_taken), .reg_we(reg_we), .wr_addr_in(wr_addr_in), .halt_in(halt_in),
    .rf_wr_ready(rf_wr_ready), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .redirect_valid(redirect_valid), .new_pc(new_pc),
    .halted(halted), .retired(retired));

  wb_buffered_stage #(.DATA_W(16), .RADDR_W(3), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .branch_pc(branch_pc), .j_addr(j_addr), .ex_out(ex_out), .mem_data(mem_data), .pc2(pc2),
    .mem_to_reg(mem_to_reg), .j_jal(j_jal), .jr_jalr(jr_jalr), .jal_jalr(jal_jalr),
    .br_taken(br_taken), .reg_we(reg_we), .wr_addr_in(wr_addr_in), .halt_in(halt_in),
    .rf_wr_ready(rf_wr_ready), .rf_wr_en(rf_wr_en4), .rf_wr_addr(rf_wr_addr4),
    .rf_wr_data(rf_wr_data4), .redirect_valid(redirect_valid4), .new_pc(new_pc4),
    .halted(halted4), .retired(retired4));

  task automatic clear_in();
    in_valid = 0; mem_to_reg = 0; j_jal = 0; jr_jalr = 0; jal_jalr = 0; br_taken = 0;
    reg_we = 0; halt_in = 0; rf_wr_ready = 0; wr_addr_in = 0;
    branch_pc = 0; j_addr = 0; ex_out = 0; mem_data = 0; pc2 = 0;
  endtask

  task automatic model_reset();
    mq.delete(); m_hs = 0; m_hsticky = 0; m_redir = 0; m_newpc = 0; m_retired = 0;
  endtask

  // Advance the reference model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    int   sz;
    bit   ready, acc, pop;
    ent_t e;
    sz    = mq.size();
    ready = (sz < DEPTH) && !m_hs;
    acc   = in_valid && ready;
    pop   = (sz > 0) && rf_wr_ready;
    if (m_hs && sz == 0) m_hsticky = 1;
    if (pop) void'(mq.pop_front());
    if (acc && reg_we) begin
      e.a = wr_addr_in;
      e.d = jal_jalr ? pc2 : (mem_to_reg ? mem_data : ex_out);
      mq.push_back(e);
    end
    if (acc && halt_in) m_hs = 1;
    m_redir = acc && (jr_jalr || j_jal || br_taken);
    if (m_redir) m_newpc = jr_jalr ? ex_out : (j_jal ? j_addr : branch_pc);
    if (acc) m_retired++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    clear_in();
    ex_out = 16'hFFFF; mem_data = 16'hABCD; pc2 = 16'h1111; j_addr = 16'h2222; branch_pc = 16'h3333;
    wr_addr_in = 3'd6; reg_we = 1; jr_jalr = 1; halt_in = 1; rf_wr_ready = 1;
    do_reset();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b want=0", rf_wr_en); end
    checks++; if (rf_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", rf_wr_addr); end
    checks++; if (rf_wr_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h want=0", rf_wr_data); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redir got=%b want=0", redirect_valid); end
    checks++; if (new_pc !== 16'h0) begin errors++; $display("FAIL reset_newpc got=%h want=0", new_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
    checks++; if (retired !== 16'h0) begin errors++; $display("FAIL reset_retired got=%0d want=0", retired); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    clear_in();
  endtask

  task automatic test_wb_select();
    clear_in(); rf_wr_ready = 1;
    in_valid = 1; reg_we = 1; mem_to_reg = 1; mem_data = 16'h1234; ex_out = 16'h5555; wr_addr_in = 3'd5;
    tick();
    checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd5, 16'h1234})
      begin errors++; $display("FAIL wb_mem got=%b/%0d/%h want=1/5/1234", rf_wr_en, rf_wr_addr, rf_wr_data); end
    mem_to_reg = 0; jal_jalr = 1; pc2 = 16'h0042; wr_addr_in = 3'd7;
    tick();
    checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd7, 16'h0042})
      begin errors++; $display("FAIL wb_link got=%b/%0d/%h want=1/7/0042", rf_wr_en, rf_wr_addr, rf_wr_data); end
    clear_in(); rf_wr_ready = 1;
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL wb_drained got=%b want=0", rf_wr_en); end
  endtask

  task automatic test_backpressure();
    logic [15:0] seen[$];
    int          acc5;
    clear_in();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; reg_we = 1; ex_out = 16'(i); wr_addr_in = 3'(i);
      tick();
      if (i == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", in_ready); end
      end
    end
    checks++; if (rf_wr_data !== 16'd1) begin errors++; $display("FAIL full_held_head got=%0d want=1", rf_wr_data); end
    rf_wr_ready = 1; acc5 = 0;
    for (int c = 0; c < 20 && seen.size() < 5; c++) begin
      if (rf_wr_en) seen.push_back(rf_wr_data);
      if (in_valid && in_ready) acc5++;
      tick();
      if (acc5 > 0) in_valid = 0;
    end
    checks++; if (seen.size() != 5) begin errors++; $display("FAIL full_drain_count got=%0d want=5", seen.size()); end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== 16'(i + 1)) begin errors++; $display("FAIL full_order[%0d] got=%0d want=%0d", i, seen[i], i + 1); end
    end
    checks++; if (acc5 != 1) begin errors++; $display("FAIL full_fifth_accepts got=%0d want=1", acc5); end
    clear_in();
  endtask

  task automatic test_redirect();
    clear_in();
    in_valid = 1; jr_jalr = 1; j_jal = 1; br_taken = 1;
    ex_out = 16'h0100; j_addr = 16'h0200; branch_pc = 16'h0300;
    tick();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL redir_pulse got=%b want=1", redirect_valid); end
    checks++; if (new_pc !== 16'h0100) begin errors++; $display("FAIL redir_prio got=%h want=0100", new_pc); end
    jr_jalr = 0; j_jal = 0; br_taken = 0; ex_out = 16'h0777;
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got=%b want=0", redirect_valid); end
    checks++; if (new_pc !== 16'h0100) begin errors++; $display("FAIL redir_hold got=%h want=0100", new_pc); end
    in_valid = 1; j_jal = 1; br_taken = 1; j_addr = 16'h0abc;
    tick();
    checks++; if (new_pc !== 16'h0abc) begin errors++; $display("FAIL redir_jal got=%h want=0abc", new_pc); end
    clear_in();
  endtask

  task automatic test_halt();
    clear_in(); do_reset();
    in_valid = 1; reg_we = 1; ex_out = 16'h00A1; wr_addr_in = 3'd1; tick();
    ex_out = 16'h00A2; wr_addr_in = 3'd2; tick();
    reg_we = 0; halt_in = 1; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got=%b want=0", in_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got=%b want=0", halted); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL halt_retired got=%0d want=3", retired); end
    clear_in(); rf_wr_ready = 1; tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_one_left got=%b want=0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_drained got=%b want=1", halted); end
    in_valid = 1; repeat (3) tick();
    checks++; if (halted !== 1'b1 || retired !== 16'd3) begin errors++; $display("FAIL halt_sticky got=%b/%0d want=1/3", halted, retired); end
    clear_in();
  endtask

  task automatic test_async_reset();
    clear_in(); do_reset();
    in_valid = 1; reg_we = 1; br_taken = 1; branch_pc = 16'h0055;
    repeat (3) tick();
    clear_in();
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b want=1", rf_wr_en); end
    #2 rst_n = 0;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL areset_en got=%b want=0", rf_wr_en); end
    checks++; if (redirect_valid !== 1'b0 || new_pc !== 16'h0) begin errors++; $display("FAIL areset_redir got=%b/%h want=0/0", redirect_valid, new_pc); end
    model_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_wrap();
    clear_in(); do_reset();
    in_valid = 1;
    repeat (17) tick();
    clear_in();
    checks++; if (retired !== 16'd17) begin errors++; $display("FAIL wrap_wide got=%0d want=17", retired); end
    checks++; if (retired4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d want=1", retired4); end
  endtask

  task automatic test_random();
    clear_in(); do_reset();
    for (int c = 0; c < 600; c++) begin
      if (m_hsticky && ($urandom_range(0, 3) == 0)) begin clear_in(); do_reset(); end
      in_valid = ($urandom_range(0, 3) != 0); reg_we = $urandom_range(0, 1);
      mem_to_reg = $urandom_range(0, 1); jal_jalr = ($urandom_range(0, 3) == 0);
      j_jal = ($urandom_range(0, 5) == 0); jr_jalr = ($urandom_range(0, 5) == 0);
      br_taken = ($urandom_range(0, 4) == 0); halt_in = ($urandom_range(0, 60) == 0);
      rf_wr_ready = $urandom_range(0, 1); wr_addr_in = 3'($urandom);
      branch_pc = 16'($urandom); j_addr = 16'($urandom); ex_out = 16'($urandom);
      mem_data = 16'($urandom); pc2 = 16'($urandom);
      tick();
      checks++; if (rf_wr_en !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_en c=%0d got=%b want=%b", c, rf_wr_en, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (rf_wr_addr !== mq[0].a || rf_wr_data !== mq[0].d)
          begin errors++; $display("FAIL rnd_head c=%0d got=%0d/%h want=%0d/%h", c, rf_wr_addr, rf_wr_data, mq[0].a, mq[0].d); end
      end
      checks++; if (in_ready !== (mq.size() < DEPTH && !m_hs)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b", c, in_ready); end
      checks++; if (redirect_valid !== m_redir || new_pc !== m_newpc)
        begin errors++; $display("FAIL rnd_redir c=%0d got=%b/%h want=%b/%h", c, redirect_valid, new_pc, m_redir, m_newpc); end
      checks++; if (halted !== (m_hsticky || (m_hs && mq.size() == 0))) begin errors++; $display("FAIL rnd_halted c=%0d got=%b", c, halted); end
      checks++; if (retired !== 16'(m_retired) || retired4 !== 4'(m_retired))
        begin errors++; $display("FAIL rnd_retired c=%0d got=%0d/%0d want=%0d", c, retired, retired4, m_retired); end
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    test_reset();
    test_wb_select();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
